// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice.
//   fetch_state_t    : sequencer FSM states (IDLE=0, FETCH=1, HALTED=2)
//   INST_W           : instruction word width
//   DEFAULT_RESET_PC : default first PC fetched after reset
package fetch_sequencer_pkg;

  localparam int unsigned INST_W           = 32;
  localparam int unsigned DEFAULT_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_skid_buffer.sv
// fetch_skid_buffer: output register plus one skid entry of {pc, inst}.
//   clk, rst (async, active-low), flush (drops both entries)
//   in_valid/in_ready/in_pc/in_inst    : upstream (returning imem data)
//   out_valid/out_ready/out_pc/out_inst: downstream (decode)
//   count                              : number of occupied entries (0..2)
module fetch_skid_buffer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        count
);

  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              out_free;

  // Output slot can take a new word when empty or draining this cycle.
  assign out_free = !out_valid || out_ready;
  assign in_ready = !skid_valid || out_ready;
  assign count    = 2'(out_valid) + 2'(skid_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_inst   <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        // Skid is older than the incoming word: it moves up first.
        out_valid  <= 1'b1;
        out_pc     <= skid_pc;
        out_inst   <= skid_inst;
        skid_valid <= in_valid;
        if (in_valid) begin
          skid_pc   <= in_pc;
          skid_inst <= in_inst;
        end
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_pc   <= in_pc;
          out_inst <= in_inst;
        end
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_inst  <= in_inst;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, drives instruction_memory one word address per
// cycle, absorbs its 1-cycle read latency and hands words to decode via
// valid/ready. Handles redirect, halt and out-of-range fault.
//   clk, rst (async, active-low)
//   imem_addr / imem_rdata         : instruction_memory interface
//   inst_valid/inst_ready/inst_out/inst_pc : decode interface
//   redirect_valid, redirect_pc    : jump/branch target (pulse)
//   halt                           : level, stops new issue
//   fault                          : sticky, fetch attempted at PC >= IMEM_DEPTH
//   perf_fetch_cnt, perf_redirect_cnt : counters when FETCH_PERF_EN is defined,
//                                       otherwise tied to zero
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned     ADDR_W     = 32,
  parameter int unsigned     IMEM_DEPTH = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              fault,
  output logic [31:0]       perf_fetch_cnt,
  output logic [15:0]       perf_redirect_cnt
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight_valid;
  logic              drain;
  logic [1:0]        buf_count;
  logic              buf_in_ready;
  logic [2:0]        occ;
  logic              issue_slot;
  logic              at_bound;

  assign imem_addr  = fetch_pc;
  assign drain      = inst_valid && inst_ready;
  // Words owed to decode after this cycle's transfer; at most two may be
  // outstanding so a returning word always finds room.
  assign occ        = 3'(inflight_valid) + 3'(buf_count) - 3'(drain);
  assign issue_slot = (occ < 3'd2);
  assign at_bound   = (fetch_pc >= ADDR_W'(IMEM_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      fault          <= 1'b0;
    end else begin
      inflight_valid <= 1'b0;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        fault    <= 1'b0;
        state    <= halt ? HALTED : FETCH;
      end else begin
        unique case (state)
          IDLE: state <= FETCH;
          FETCH: begin
            if (halt) begin
              state <= HALTED;
            end else if (issue_slot) begin
              if (at_bound) begin
                fault <= 1'b1;
                state <= HALTED;
              end else begin
                fetch_pc       <= fetch_pc + ADDR_W'(1);
                inflight_valid <= 1'b1;
                inflight_pc    <= fetch_pc;
              end
            end
          end
          // Dropping halt resumes at fetch_pc; a fault waits for a redirect.
          HALTED: if (!halt && !fault) state <= FETCH;
          default: state <= IDLE;
        endcase
      end
    end
  end

  fetch_skid_buffer #(
    .PC_W (ADDR_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .in_valid  (inflight_valid),
    .in_ready  (buf_in_ready),
    .in_pc     (inflight_pc),
    .in_inst   (imem_rdata),
    .out_valid (inst_valid),
    .out_ready (inst_ready),
    .out_pc    (inst_pc),
    .out_inst  (inst_out),
    .count     (buf_count)
  );

  a_return_has_room: assert property (
    @(posedge clk) disable iff (!rst) inflight_valid |-> buf_in_ready
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [15:0] redirect_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (drain)          fetch_cnt    <= fetch_cnt + 32'd1;
      if (redirect_valid) redirect_cnt <= redirect_cnt + 16'd1;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt;
  assign perf_redirect_cnt = redirect_cnt;
`else
  assign perf_fetch_cnt    = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fault;
  logic [31:0] perf_fetch_cnt;
  logic [15:0] perf_redirect_cnt;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int red_cnt = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W     (32),
    .IMEM_DEPTH (64),
    .RESET_PC   (32'd0)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .inst_valid        (inst_valid),
    .inst_ready        (inst_ready),
    .inst_out          (inst_out),
    .inst_pc           (inst_pc),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .halt              (halt),
    .fault             (fault),
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
  );

  // instruction_memory model: registered read, mem[i] = i + 100
  always @(posedge clk)
    imem_rdata <= (imem_addr < 32'd64) ? imem_addr + 32'd100 : 32'hDEADBEEF;

  // Reference transfer / redirect counts since the last reset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt = 0;
      red_cnt = 0;
    end else begin
      if (inst_valid && inst_ready) acc_cnt++;
      if (redirect_valid) red_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_perf(input string tag);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'(acc_cnt));
    chk({tag, "_perf_redir"}, {16'd0, perf_redirect_cnt}, 32'(red_cnt));
`else
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'd0);
    chk({tag, "_perf_redir"}, {16'd0, perf_redirect_cnt}, 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ready;
    logic        hlt;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic h, input logic rv, input logic [31:0] rp,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ea);
    vec_t v;
    v.ready = r; v.hlt = h; v.redir = rv; v.rpc = rp;
    v.exp_valid = ev; v.exp_pc = ep; v.exp_addr = ea;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[25];
    int   n;
    int   idx;
    logic found;
    logic [31:0] got_pc[2];
    logic [31:0] got_out[2];
    logic        saw_bad;

    //          ready halt redir rpc    valid pc  addr
    tbl[0]  = mk(1, 0, 0, 0,     0, 0,  0);   // leave IDLE
    tbl[1]  = mk(1, 0, 0, 0,     0, 0,  1);
    tbl[2]  = mk(1, 0, 0, 0,     1, 0,  2);   // first word, 2 cycles after IDLE
    tbl[3]  = mk(1, 0, 0, 0,     1, 1,  3);
    tbl[4]  = mk(1, 0, 0, 0,     1, 2,  4);
    tbl[5]  = mk(1, 0, 0, 0,     1, 3,  5);
    tbl[6]  = mk(0, 0, 0, 0,     1, 3,  5);   // stall: 103 held, 104 in skid
    tbl[7]  = mk(0, 0, 0, 0,     1, 3,  5);
    tbl[8]  = mk(0, 0, 0, 0,     1, 3,  5);
    tbl[9]  = mk(1, 0, 0, 0,     1, 4,  6);   // release
    tbl[10] = mk(1, 1, 0, 0,     1, 5,  6);   // halt at fetch_pc 6
    tbl[11] = mk(1, 1, 0, 0,     0, 0,  6);
    tbl[12] = mk(1, 1, 0, 0,     0, 0,  6);
    tbl[13] = mk(1, 0, 0, 0,     0, 0,  6);   // halt drops
    tbl[14] = mk(1, 0, 0, 0,     0, 0,  7);
    tbl[15] = mk(1, 0, 0, 0,     1, 6,  8);   // resumed at 6
    tbl[16] = mk(1, 0, 0, 0,     1, 7,  9);
    tbl[17] = mk(1, 0, 1, 20,    0, 0,  20);  // redirect, pc 8 in flight dropped
    tbl[18] = mk(1, 0, 0, 0,     0, 0,  21);
    tbl[19] = mk(1, 0, 0, 0,     1, 20, 22);
    tbl[20] = mk(1, 0, 0, 0,     1, 21, 23);
    tbl[21] = mk(0, 0, 0, 0,     1, 21, 23);  // skid fills with 22
    tbl[22] = mk(0, 0, 1, 40,    0, 0,  40);  // redirect clears output and skid
    tbl[23] = mk(1, 0, 0, 0,     0, 0,  41);
    tbl[24] = mk(1, 0, 0, 0,     1, 40, 42);

    rst = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_out", inst_out, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk_perf("rst");
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      inst_ready     = tbl[i].ready;
      halt           = tbl[i].hlt;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk($sformatf("v%0d_pc", i), inst_pc, tbl[i].exp_pc);
        chk($sformatf("v%0d_out", i), inst_out, tbl[i].exp_pc + 32'd100);
      end
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_fault", i), {31'd0, fault}, 32'd0);
    end
    redirect_valid = 1'b0;
    halt = 1'b0;
    inst_ready = 1'b1;

    // Run into the end of memory: 62 and 63 delivered, fault instead of 64
    redirect_valid = 1'b1;
    redirect_pc = 32'd62;
    tick();
    redirect_valid = 1'b0;
    chk("r62_addr", imem_addr, 32'd62);
    chk("r62_fault", {31'd0, fault}, 32'd0);
    n = 0;
    saw_bad = 1'b0;
    got_pc[0] = '0; got_pc[1] = '0; got_out[0] = '0; got_out[1] = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (inst_valid) begin
        if (n < 2) begin
          got_pc[n]  = inst_pc;
          got_out[n] = inst_out;
        end
        if (inst_pc >= 32'd64) saw_bad = 1'b1;
        n++;
      end
    end
    chk("end_count", 32'(n), 32'd2);
    chk("end_pc0", got_pc[0], 32'd62);
    chk("end_out0", got_out[0], 32'd162);
    chk("end_pc1", got_pc[1], 32'd63);
    chk("end_out1", got_out[1], 32'd163);
    chk("end_no64", {31'd0, saw_bad}, 32'd0);
    chk("end_fault", {31'd0, fault}, 32'd1);
    chk("end_addr", imem_addr, 32'd64);

    // Redirect clears the fault and restarts at 0
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    tick();
    redirect_valid = 1'b0;
    chk("r0_fault", {31'd0, fault}, 32'd0);
    chk("r0_addr", imem_addr, 32'd0);
    found = 1'b0;
    idx = -1;
    for (int c = 0; c < 6 && !found; c++) begin
      tick();
      if (inst_valid) begin
        found = 1'b1;
        idx = c;
      end
    end
    chk("r0_found", {31'd0, found}, 32'd1);
    chk("r0_latency", 32'(idx), 32'd1);
    chk("r0_pc", inst_pc, 32'd0);
    chk("r0_out", inst_out, 32'd100);
    tick();
    tick();
    chk("r0_pc2", inst_pc, 32'd2);
    chk_perf("run");

    // Asynchronous reset mid-stream
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_fault", {31'd0, fault}, 32'd0);
    chk_perf("arst");
    tick();
    rst = 1'b1;
    found = 1'b0;
    idx = -1;
    for (int c = 0; c < 6 && !found; c++) begin
      tick();
      if (inst_valid) begin
        found = 1'b1;
        idx = c;
      end
    end
    chk("rel_found", {31'd0, found}, 32'd1);
    chk("rel_latency", 32'(idx), 32'd2);
    chk("rel_pc", inst_pc, 32'd0);
    chk("rel_out", inst_out, 32'd100);
    tick();
    chk("rel_pc1", inst_pc, 32'd1);
    chk_perf("rel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
